matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_pkg.sv | 18 +
 rtl/matrix_index_counter.sv | 41 ++++
 rtl/matrix_loader.sv | 127 ++++++++++++
 tb/tb_matrix_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared matrix dimensions, loader state enum and dimension check
package matrix_pkg;

  localparam int MAT_DIM   = 5;
  localparam int MAT_ELEMS = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic dims_ok(input logic [2:0] rows, input logic [2:0] cols);
    return (rows != 3'd0) && (cols != 3'd0) &&
           (rows <= 3'(MAT_DIM)) && (cols <= 3'(MAT_DIM));
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// rtl/matrix_index_counter.sv - row-major row/col walker with last-element flag
module matrix_index_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_adv,
  input  logic [2:0] i_rows,
  input  logic [2:0] i_cols,
  output logic [2:0] o_row,
  output logic [2:0] o_col,
  output logic       o_last
);

  logic [2:0] r_row;
  logic [2:0] r_col;
  logic       w_col_wrap;

  assign w_col_wrap = (r_col == i_cols - 3'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= 3'd0;
      r_col <= 3'd0;
    end else if (i_clr) begin
      r_row <= 3'd0;
      r_col <= 3'd0;
    end else if (i_adv) begin
      if (w_col_wrap) begin
        r_col <= 3'd0;
        r_row <= r_row + 3'd1;
      end else begin
        r_col <= r_col + 3'd1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = (r_row == i_rows - 3'd1) && w_col_wrap;

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - loads an r x c matrix (up to 5x5) row-major into flat storage; MATRIX_LOADER_VALUE_CHECK_EN enables element range checking
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int MAX_VAL    = 9
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [2:0]                      dim_r,
  input  logic [2:0]                      dim_c,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  input  logic                            clear,
  output logic [2:0]                      r_out,
  output logic [2:0]                      c_out,
  output logic [MAT_ELEMS*DATA_WIDTH-1:0] data_out,
  output logic                            mat_valid,
  output logic                            busy,
  output logic                            err
);

`ifdef MATRIX_LOADER_VALUE_CHECK_EN
  localparam logic VALUE_CHECK = 1'b1;
`else
  localparam logic VALUE_CHECK = 1'b0;
`endif

  localparam logic [DATA_WIDTH-1:0] MAX_VAL_W = DATA_WIDTH'(MAX_VAL);

  state_t                            r_state;
  logic [2:0]                        r_rows;
  logic [2:0]                        r_cols;
  logic [MAT_ELEMS*DATA_WIDTH-1:0]   r_data;
  logic                              r_err;

  logic       w_hs;
  logic       w_val_bad;
  logic       w_cnt_clr;
  logic [2:0] w_row;
  logic [2:0] w_col;
  logic       w_last;
  logic [4:0] w_idx;

  assign w_hs      = in_valid && (r_state == ST_LOAD);
  assign w_val_bad = VALUE_CHECK && (in_data > MAX_VAL_W);
  // Counters sit at zero outside LOAD, so a new load always begins at slot 0.
  assign w_cnt_clr = (r_state != ST_LOAD) || clear || (w_hs && w_val_bad);
  assign w_idx     = 5'(w_row) * 5'(MAT_DIM) + 5'(w_col);

  matrix_index_counter u_index (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_cnt_clr),
    .i_adv   (w_hs),
    .i_rows  (r_rows),
    .i_cols  (r_cols),
    .o_row   (w_row),
    .o_col   (w_col),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_rows  <= 3'd0;
      r_cols  <= 3'd0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !clear) begin
            if (dims_ok(dim_r, dim_c)) begin
              r_rows  <= dim_r;
              r_cols  <= dim_c;
              r_data  <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (clear) begin
            r_rows  <= 3'd0;
            r_cols  <= 3'd0;
            r_data  <= '0;
            r_state <= ST_IDLE;
          end else if (w_hs) begin
            if (w_val_bad) begin
              r_err   <= 1'b1;
              r_rows  <= 3'd0;
              r_cols  <= 3'd0;
              r_data  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
              if (w_last) r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (clear) begin
            r_rows  <= 3'd0;
            r_cols  <= 3'd0;
            r_data  <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign busy      = (r_state == ST_LOAD);
  assign mat_valid = (r_state == ST_DONE);
  assign err       = r_err;
  assign r_out     = r_rows;
  assign c_out     = r_cols;
  assign data_out  = r_data;

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - scoreboard bench for matrix_loader
module tb_matrix_loader;

  localparam int DW = 9;
  localparam int FW = 25 * DW;

  typedef struct {
    logic [FW-1:0] d;
    logic [2:0]    r;
    logic [2:0]    c;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    dim_r = 3'd0;
  logic [2:0]    dim_c = 3'd0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          clear = 1'b0;
  logic          in_ready;
  logic [2:0]    r_out;
  logic [2:0]    c_out;
  logic [FW-1:0] data_out;
  logic          mat_valid;
  logic          busy;
  logic          err;

  int   checks = 0;
  int   errors = 0;
  int   vals[25];
  exp_t sb[$];
  exp_t mon_e;
  logic prev_mv = 1'b0;

  matrix_loader #(.DATA_WIDTH(DW), .MAX_VAL(9)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .dim_r     (dim_r),
    .dim_c     (dim_c),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clear     (clear),
    .r_out     (r_out),
    .c_out     (c_out),
    .data_out  (data_out),
    .mat_valid (mat_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input int r, input int c);
    exp_t e;
    e.d = '0;
    e.r = 3'(r);
    e.c = 3'(c);
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++)
        e.d[(5*i+j)*DW +: DW] = DW'(vals[i*c+j]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int r, input int c);
    start = 1'b1;
    dim_r = 3'(r);
    dim_c = 3'(c);
    step();
    start = 1'b0;
  endtask

  task automatic send(input int v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = DW'(v);
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check("send_timeout", 256'(in_ready), 256'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && mat_valid && !prev_mv) begin
      if (sb.size() == 0) begin
        check("unexpected_mat_valid", 256'(mat_valid), 256'(0));
      end else begin
        mon_e = sb.pop_front();
        check("sb_data", 256'(data_out), 256'(mon_e.d));
        check("sb_r_out", 256'(r_out), 256'(mon_e.r));
        check("sb_c_out", 256'(c_out), 256'(mon_e.c));
      end
    end
    prev_mv = mat_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_mat_valid", 256'(mat_valid), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_dims", 256'({r_out, c_out}), 256'(0));
    check("rst_data", 256'(data_out), 256'(0));
    step();
    reset_n = 1'b1;
    step();

    // 2x3, back-to-back elements 1..6
    for (int i = 0; i < 6; i++) vals[i] = i + 1;
    sb.push_back(mk_exp(2, 3));
    start_load(2, 3);
    check("load_busy", 256'(busy), 256'(1));
    check("load_in_ready", 256'(in_ready), 256'(1));
    check("load_dims", 256'({r_out, c_out}), 256'({3'd2, 3'd3}));
    for (int i = 0; i < 6; i++) begin
      send(vals[i]);
      if (i == 4) check("mv_before_last", 256'(mat_valid), 256'(0));
    end
    check("mv_latency", 256'(mat_valid), 256'(1));
    check("done_in_ready", 256'(in_ready), 256'(0));
    check("done_busy", 256'(busy), 256'(0));
    check("slot3_zero", 256'(data_out[3*DW +: DW]), 256'(0));
    check("slot7", 256'(data_out[7*DW +: DW]), 256'(6));
    step();
    check("done_hold", 256'(mat_valid), 256'(1));
    do_clear();
    check("clr_mv", 256'(mat_valid), 256'(0));
    check("clr_data", 256'(data_out), 256'(0));
    check("clr_dims", 256'({r_out, c_out}), 256'(0));

    // illegal dims
    start_load(0, 3);
    check("err_0x3", 256'(err), 256'(1));
    check("err_0x3_idle", 256'({in_ready, busy}), 256'(0));
    step();
    check("err_0x3_pulse", 256'(err), 256'(0));
    start_load(6, 1);
    check("err_6x1", 256'(err), 256'(1));
    check("err_6x1_idle", 256'({in_ready, busy}), 256'(0));
    step();
    check("err_6x1_pulse", 256'(err), 256'(0));
    check("err_dims", 256'({r_out, c_out}), 256'(0));

    // 5x5, in_valid every other cycle
    for (int i = 0; i < 25; i++) vals[i] = (i % 9) + 1;
    sb.push_back(mk_exp(5, 5));
    start_load(5, 5);
    for (int i = 0; i < 25; i++) begin
      send(vals[i]);
      if (i < 24) begin
        check("busy_5x5", 256'(busy), 256'(1));
        step();
        check("busy_gap", 256'(busy), 256'(1));
      end
    end
    check("mv_5x5", 256'(mat_valid), 256'(1));
    check("slot24", 256'(data_out[24*DW +: DW]), 256'(vals[24]));
    do_clear();

    // clear after 3 of 9, then 1x1 load of 7
    start_load(3, 3);
    for (int i = 0; i < 3; i++) send(i + 1);
    do_clear();
    check("abort_busy", 256'({busy, in_ready, mat_valid}), 256'(0));
    check("abort_data", 256'(data_out), 256'(0));
    vals[0] = 7;
    sb.push_back(mk_exp(1, 1));
    start_load(1, 1);
    send(7);
    check("mv_1x1", 256'(mat_valid), 256'(1));
    check("slot0_1x1", 256'(data_out[DW-1:0]), 256'(7));
    do_clear();

    // async reset mid-LOAD
    start_load(3, 3);
    send(1);
    send(2);
    reset_n = 1'b0;
    #1;
    check("arst_flags", 256'({in_ready, busy, mat_valid, err}), 256'(0));
    check("arst_dims", 256'({r_out, c_out}), 256'(0));
    check("arst_data", 256'(data_out), 256'(0));
    step();
    reset_n = 1'b1;
    step();
    check("arst_no_err", 256'(err), 256'(0));

    // start and clear together in DONE
    vals[0] = 4;
    vals[1] = 5;
    sb.push_back(mk_exp(1, 2));
    start_load(1, 2);
    send(4);
    send(5);
    check("mv_1x2", 256'(mat_valid), 256'(1));
    start = 1'b1;
    clear = 1'b1;
    dim_r = 3'd2;
    dim_c = 3'd2;
    step();
    start = 1'b0;
    clear = 1'b0;
    check("sc_idle", 256'({mat_valid, busy}), 256'(0));
    step();
    check("sc_no_load", 256'(busy), 256'(0));

    // element above MAX_VAL
    vals[0] = 3;
    vals[1] = 12;
    vals[2] = 4;
    vals[3] = 5;
`ifdef MATRIX_LOADER_VALUE_CHECK_EN
    start_load(2, 2);
    send(3);
    send(12);
    check("vc_err", 256'(err), 256'(1));
    check("vc_idle", 256'({busy, mat_valid}), 256'(0));
    check("vc_data", 256'(data_out), 256'(0));
    step();
    check("vc_err_pulse", 256'(err), 256'(0));
`else
    sb.push_back(mk_exp(2, 2));
    start_load(2, 2);
    for (int i = 0; i < 4; i++) send(vals[i]);
    check("vc_mv", 256'(mat_valid), 256'(1));
    check("vc_slot1", 256'(data_out[DW +: DW]), 256'(12));
    check("vc_no_err", 256'(err), 256'(0));
    do_clear();
`endif

    step();
    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
